// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready word to serial bitstream with a one-word holding buffer
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, hold, hold_n, shifted;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic             hold_full, hold_full_n, word_done_n;
  logic             accept, consume, last;
  assign data_ready   = !hold_full;
  assign accept       = data_valid & data_ready;
  assign consume      = (state == SHIFT) & shift_en;
  assign last         = consume & (bcnt == BW'(WIDTH - 1));
  assign shifted      = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign serial_valid = (state == SHIFT);
  assign serial_out   = (state == SHIFT) ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;
  assign busy         = (state == SHIFT) | hold_full;
  // next state: load from input or hold, shift on consume, park the early word in hold
  always_comb begin
    state_n     = state;
    sreg_n      = sreg;
    bcnt_n      = bcnt;
    hold_n      = hold;
    hold_full_n = hold_full;
    word_done_n = 1'b0;
    if (state == IDLE) begin
      if (accept) begin
        sreg_n  = data_in;
        bcnt_n  = '0;
        state_n = SHIFT;
      end
    end else begin
      if (last) begin
        word_done_n = 1'b1;
        bcnt_n      = '0;
        if (hold_full) begin
          sreg_n      = hold;
          hold_full_n = 1'b0;
        end else if (accept) sreg_n = data_in;
        else state_n = IDLE;
      end else if (consume) begin
        sreg_n = shifted;
        bcnt_n = bcnt + 1'b1;
      end
      if (accept && !last) begin
        hold_n      = data_in;
        hold_full_n = 1'b1;
      end
    end
  end
  // state registers; reset discards any in-flight and held word
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      bcnt      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      bcnt      <= bcnt_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      word_done <= word_done_n;
    end
  end
endmodule
